// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with write-back bypass and pending-write scoreboard
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_used,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     hazard,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [XLEN-1:0]          wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_count
);

    // Register 0 has no storage; entries start at 1.
    logic [XLEN-1:0]  regs_q [1:NREGS-1];
    logic [NREGS-1:1] busy_q;
    logic [NREGS-1:1] busy_d;
    logic [ADDR_W:0]  count_q;
    logic [ADDR_W:0]  count_d;
    logic [NREGS-1:1] wr_sel;
    logic [NREGS-1:1] issue_sel;

    // One-hot decode; addresses 0 and >= NREGS select nothing.
    always_comb begin
        wr_sel    = '0;
        issue_sel = '0;
        for (int r = 1; r < NREGS; r++) begin
            wr_sel[r]    = wr_en && (wr_addr == ADDR_W'(r));
            issue_sel[r] = issue_en && (issue_addr == ADDR_W'(r));
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int r = 1; r < NREGS; r++) begin
                if (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    rd_data[i*XLEN +: XLEN] = wr_sel[r] ? wr_data : regs_q[r];
                    rd_busy[i]              = busy_q[r] && !wr_sel[r];
                end
            end
        end
    end

    assign hazard     = |(rd_busy & rd_used);
    assign busy_count = count_q;

    // A same-edge issue overrides the write-back clear: the newer producer owns the register.
    always_comb begin
        busy_d  = flush ? '0 : ((busy_q & ~wr_sel) | issue_sel);
        count_d = '0;
        for (int r = 1; r < NREGS; r++) begin
            count_d = count_d + {{ADDR_W{1'b0}}, busy_d[r]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 1; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wr_sel[r]) begin
                    regs_q[r] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the ID stage, with N combinational read ports and one synchronous write-back port.
- Same-cycle write-to-read bypass.
- Per-register pending-write scoreboard: busy bit set when an instruction that writes the register issues, cleared on its write-back. Used to raise a RAW hazard/stall to the pipeline.
- Sits between the decoder (source/dest addresses) and the EX/WB stages (write-back).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; register 0 hard-wired to zero.
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= NREGS.
- NUM_RD, 2, number of read ports.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_used  input  NUM_RD  port i's operand is actually consumed this cycle; gates hazard.
- rd_data  output  NUM_RD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy  output  NUM_RD  port i's register has a pending write not yet bypassable.
- hazard  output  1  OR over i of (rd_busy[i] & rd_used[i]).
- wr_en  input  1  write-back valid.
- wr_addr  input  ADDR_W  write-back destination.
- wr_data  input  XLEN  write-back data.
- issue_en  input  1  an instruction writing issue_addr leaves ID this cycle.
- issue_addr  input  ADDR_W  destination of the issuing instruction.
- flush  input  1  pipeline flush; clears all busy bits.
- busy_count  output  ADDR_W+1  number of registers currently marked busy.

Behaviour:
- Reset (reset=0, async):
  - All NREGS registers cleared to 0.
  - All busy bits cleared; busy_count=0.
  - Outputs then reflect the cleared state combinationally: rd_data=0, rd_busy=0, hazard=0.
  - Reset mid-operation discards all pending writes and busy bits immediately.
- Register 0:
  - Reads always return 0.
  - Writes to it are ignored.
  - issue_addr=0 never sets a busy bit; rd_busy is always 0 for address 0.
- Addresses >= NREGS: reads return 0; writes and issues are ignored.
- Read, combinational, zero latency:
  - rd_data[i] = wr_data if wr_en && wr_addr==rd_addr[i] && rd_addr[i]!=0.
  - Otherwise rd_data[i] = the stored register value.
- Write: on the rising edge with wr_en and wr_addr!=0, the register takes wr_data; visible from storage on the next cycle (bypassed in the same cycle).
- rd_busy[i], combinational:
  - rd_busy[i] = busy[rd_addr[i]] && !(wr_en && wr_addr==rd_addr[i]).
  - A same-cycle write-back therefore resolves the hazard through the bypass.
- Busy update on the rising edge, in priority order:
  1. flush=1: all busy bits go to 0. A coincident wr_en still writes data; a coincident issue_en is ignored.
  2. Otherwise, wr_en clears busy[wr_addr]; then issue_en sets busy[issue_addr].
  3. Same address in both the same cycle: the bit ends set (new producer wins).
- issue_en to an already-busy register: the bit stays set. There is no count per register, so only one outstanding write per register is tracked. The pipeline guarantees in-order write-back.
- wr_en to a non-busy register: data is written normally; busy is unchanged (stays 0).
- busy_count:
  - Registered population count of the busy bits, updated on the same edge as the bits.
  - Range 0..NREGS-1; it cannot overflow because register 0 is never busy.
- hazard is purely combinational from the current state and inputs; no internal stall state.

Test Plan:
1. Reset, then read all addresses -> every rd_data=0, rd_busy=0, busy_count=0. Write x0=0xDEADBEEF, then read x0 -> 0.
2. Bypass and write:
   - Write x5=0x12345678 with rd_addr[0]=5 in the same cycle -> rd_data[0]=0x12345678 combinationally.
   - Next cycle with wr_en=0 -> still 0x12345678 from storage.
3. Scoreboard:
   - issue_addr=7 -> next cycle busy_count=1.
   - rd_addr[1]=7 with rd_used[1]=1 -> rd_busy[1]=1 and hazard=1.
   - rd_used[1]=0 -> hazard=0.
   - Write-back x7=0xA5 -> same cycle rd_busy[1]=0, rd_data[1]=0xA5; next cycle busy_count=0.
4. Simultaneous events:
   - Write-back x9 plus issue x9 in the same edge -> busy[9] stays 1 and busy_count unchanged.
   - Issue x3 plus write-back x4 where x4 was busy -> count unchanged, busy set on x3 only.
5. Flush and reset:
   - Issue x1, x2, x3 -> busy_count=3.
   - flush -> busy_count=0, hazard=0, register contents preserved.
   - Issue x2, then assert reset mid-cycle asynchronously -> busy_count=0 and x2 reads 0 immediately.
6. Parameters: NUM_RD=3, NREGS=16, ADDR_W=4 -> three ports read independently. Address 0xF is valid and no address aliases onto another register.
